// File: rtl/fp_round_scheduler.sv
// Round-robin front end for a single shared FP add/normalise/round datapath.
// One operand pair is in flight at a time; the owner gets a one-cycle ack with the rounded result.
module fp_round_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opA,
  input  logic [NREQ*W-1:0] opB,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      result,
  output logic              err,
  output logic [W-1:0]      dp_opA,
  output logic [W-1:0]      dp_opB,
  output logic              dp_validIn,
  output logic              dp_clear,
  input  logic              dp_valid,
  input  logic [W-1:0]      dp_result,
  input  logic              dp_invalid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_sticky_q, err_sticky_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    result_q, result_d;
  logic            err_q, err_d;
  logic [W-1:0]    dp_opa_q, dp_opa_d;
  logic [W-1:0]    dp_opb_q, dp_opb_d;
  logic            dp_valid_in_q, dp_valid_in_d;
  logic            dp_clear_q, dp_clear_d;

  logic            grant_found_s;
  logic [PW-1:0]   grant_idx_s;
  logic [PW:0]     cand_s;
  logic [W-1:0]    sel_a_s, sel_b_s;
  logic [NREQ-1:0] owner_onehot_s;

  // First requesting index at or above rr_ptr, wrapping past NREQ-1
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand_s >= (PW+1)'(NREQ)) begin
        cand_s = cand_s - (PW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req[cand_s[PW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[PW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Operand slice of the winning requester and one-hot of the current owner
  always_comb begin
    sel_a_s        = '0;
    sel_b_s        = '0;
    owner_onehot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == PW'(i)) begin
        sel_a_s = opA[i*W +: W];
        sel_b_s = opB[i*W +: W];
      end else begin
        sel_a_s = sel_a_s;
      end
      owner_onehot_s[i] = (owner_q == PW'(i));
    end
  end

  // Transaction FSM next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    timer_d       = timer_q;
    err_sticky_d  = err_sticky_q;
    ack_d         = '0;
    result_d      = result_q;
    err_d         = 1'b0;
    dp_opa_d      = dp_opa_q;
    dp_opb_d      = dp_opb_q;
    dp_valid_in_d = dp_valid_in_q;
    dp_clear_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          owner_d  = grant_idx_s;
          dp_opa_d = sel_a_s;
          dp_opb_d = sel_b_s;
          if (grant_idx_s == PW'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx_s + PW'(1);
          end
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        dp_valid_in_d = 1'b1;
        timer_d       = '0;
        state_d       = S_WAIT;
      end

      S_WAIT: begin
        timer_d      = timer_q + TW'(1);
        err_sticky_d = err_sticky_q | dp_invalid;
        // A valid on the last permitted cycle still counts as a real result
        if (dp_valid) begin
          result_d      = dp_result;
          ack_d         = owner_onehot_s;
          err_d         = err_sticky_q | dp_invalid;
          dp_valid_in_d = 1'b0;
          dp_clear_d    = 1'b1;
          state_d       = S_ACK;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          result_d      = '0;
          err_sticky_d  = 1'b1;
          ack_d         = owner_onehot_s;
          err_d         = 1'b1;
          dp_valid_in_d = 1'b0;
          dp_clear_d    = 1'b1;
          state_d       = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_ACK: begin
        err_sticky_d = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d       = S_IDLE;
        dp_valid_in_d = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous reset drops any transaction in flight
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      timer_q       <= '0;
      err_sticky_q  <= 1'b0;
      ack_q         <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      dp_opa_q      <= '0;
      dp_opb_q      <= '0;
      dp_valid_in_q <= 1'b0;
      dp_clear_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      timer_q       <= timer_d;
      err_sticky_q  <= err_sticky_d;
      ack_q         <= ack_d;
      result_q      <= result_d;
      err_q         <= err_d;
      dp_opa_q      <= dp_opa_d;
      dp_opb_q      <= dp_opb_d;
      dp_valid_in_q <= dp_valid_in_d;
      dp_clear_q    <= dp_clear_d;
    end
  end

  assign ack        = ack_q;
  assign result     = result_q;
  assign err        = err_q;
  assign dp_opA     = dp_opa_q;
  assign dp_opB     = dp_opb_q;
  assign dp_validIn = dp_valid_in_q;
  assign dp_clear   = dp_clear_q;

endmodule

// File: tb/tb_fp_round_scheduler.sv
// Bench for fp_round_scheduler: a cycle-level datapath model answers dp_validIn,
// and a round-robin model predicts owner, latency, result and error flag.
module tb_fp_round_scheduler;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 8;

  logic              Clock;
  logic              Reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opA;
  logic [NREQ*W-1:0] opB;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      result;
  logic              err;
  logic [W-1:0]      dp_opA;
  logic [W-1:0]      dp_opB;
  logic              dp_validIn;
  logic              dp_clear;
  logic              dp_valid;
  logic [W-1:0]      dp_result;
  logic              dp_invalid;

  int ncmp;
  int nfail;
  int m_ptr;

  fp_round_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .opA(opA), .opB(opB),
    .ack(ack), .result(result), .err(err), .dp_opA(dp_opA), .dp_opB(dp_opB),
    .dp_validIn(dp_validIn), .dp_clear(dp_clear), .dp_valid(dp_valid),
    .dp_result(dp_result), .dp_invalid(dp_invalid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after ptr, wrapping modulo NREQ
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  // One transaction from an IDLE cycle with req already applied.
  // lat: WAIT cycle (1-based) on which dp_valid rises, 0 = never.
  // inv_at: WAIT cycle carrying dp_invalid, 0 = none.
  task automatic do_txn(input int lat, input int inv_at, input logic [W-1:0] res,
                        input bit drop, input bit spur, output logic [NREQ-1:0] got_ack);
    int owner, cycles, vcnt, wait_n;
    logic [W-1:0] ea, eb;
    logic exp_err;
    owner  = pick(req, m_ptr);
    m_ptr  = (owner + 1) % NREQ;
    ea     = opA[owner*W +: W];
    eb     = opB[owner*W +: W];
    wait_n = (lat > 0) ? lat : TIMEOUT;
    exp_err = (lat == 0) || (inv_at >= 1 && inv_at <= wait_n);
    dp_valid   = spur;
    dp_invalid = 1'b0;
    dp_result  = $urandom;
    cycles = 1;
    vcnt   = 0;
    while (cycles < 40) begin
      @(posedge Clock); #1;
      cycles++;
      if (ack !== '0) break;
      if (drop && cycles == 2) req[owner] = 1'b0;
      if (dp_validIn) begin
        vcnt++;
        if (vcnt == 1) begin
          check("dp_opA", dp_opA, ea);
          check("dp_opB", dp_opB, eb);
        end
        dp_valid   = (vcnt == lat);
        dp_invalid = (vcnt == inv_at);
        dp_result  = (vcnt == lat) ? res : W'($urandom);
      end else begin
        dp_valid   = spur;
        dp_invalid = 1'b0;
      end
    end
    got_ack    = ack;
    dp_valid   = 1'b0;
    dp_invalid = 1'b0;
    check("ack", 32'(ack), 32'(1) << owner);
    check("latency", cycles, 3 + wait_n);
    check("result", result, (lat > 0) ? res : '0);
    check("err", 32'(err), 32'(exp_err));
    check("clear_in_ack", 32'(dp_clear), 32'd1);
    check("validIn_in_ack", 32'(dp_validIn), 32'd0);
    @(posedge Clock); #1;
    check("ack_after", 32'(ack), 32'd0);
    check("clear_after", 32'(dp_clear), 32'd0);
  endtask

  logic [NREQ-1:0] got;
  logic [NREQ-1:0] fair_exp [5];
  int lat_r, inv_r, wn;

  initial begin
    ncmp = 0; nfail = 0; m_ptr = 0;
    Reset = 1'b1; req = '0; opA = '0; opB = '0;
    dp_valid = 1'b0; dp_result = '0; dp_invalid = 1'b0;
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;

    repeat (3) @(posedge Clock);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dp_opA", dp_opA, 32'd0);
    check("rst_dp_opB", dp_opB, 32'd0);
    check("rst_validIn", 32'(dp_validIn), 32'd0);
    check("rst_clear", 32'(dp_clear), 32'd0);
    Reset = 1'b0;

    // Fairness with every requester held high
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      opA[i*W +: W] = $urandom;
      opB[i*W +: W] = $urandom;
    end
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 0, $urandom, 1'b0, (i % 2) == 1, got);
      check("fair_order", 32'(got), 32'(fair_exp[i]));
    end

    // Single request, 1.0 + 1.0
    req = 4'b0001;
    opA[0 +: W] = 32'h3F800000;
    opB[0 +: W] = 32'h3F800000;
    do_txn(1, 0, 32'h40000000, 1'b0, 1'b0, got);

    // Round-up path, requester drops req after grant
    req = 4'b0010;
    do_txn(2, 0, 32'h40400001, 1'b1, 1'b1, got);
    check("drop_ack", 32'(got), 32'h2);

    // outputInvalid in the first WAIT cycle, then a clean transaction
    req = 4'b0001;
    do_txn(2, 1, 32'h7FC00000, 1'b0, 1'b0, got);
    do_txn(1, 0, 32'h12345678, 1'b0, 1'b0, got);

    // No dp_valid at all
    req = 4'b0100;
    do_txn(0, 0, 32'hDEADBEEF, 1'b0, 1'b0, got);

    // Reset in WAIT, with the pointer sitting at 3
    req = 4'b1010;
    repeat (3) begin @(posedge Clock); #1; end
    check("pre_rst_validIn", 32'(dp_validIn), 32'd1);
    check("pre_rst_owner", dp_opA, opA[3*W +: W]);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("wrst_ack", 32'(ack), 32'd0);
    check("wrst_bus", {dp_validIn, dp_clear, err, 29'd0}, 32'd0);
    check("wrst_result", result, 32'd0);
    check("wrst_dp_opA", dp_opA, 32'd0);
    Reset = 1'b0;
    m_ptr = 0;
    do_txn(1, 0, $urandom, 1'b0, 1'b0, got);
    check("wrst_regrant", 32'(got), 32'h2);

    // Randomised traffic
    for (int n = 0; n < 30; n++) begin
      req = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        opA[i*W +: W] = $urandom;
        opB[i*W +: W] = $urandom;
      end
      lat_r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2);
      wn    = (lat_r > 0) ? lat_r : TIMEOUT;
      inv_r = ($urandom_range(0, 2) == 0) ? $urandom_range(1, wn) : 0;
      do_txn(lat_r, inv_r, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
